// File: rtl/fetch_unit.sv
// fetch_unit: single-issue instruction fetch stage with stall, redirect and
// debug-hold control.
//
// State table
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | bubble cycle: memory is presenting pc's word, nothing issued
//   S_RUN   | fetching: one instruction per edge unless stalled/redirected
//   S_DEBUG | debug loader owns memory; pc parked at RESET_PC
//
// Ports
//   clk            rising-edge clock
//   nrst           asynchronous active-low reset
//   imem_addr      word index into instruction memory ({2'b00, pc[31:2]})
//   imem_instr     instruction word at imem_addr (memory reads on falling edge)
//   stall          decode cannot accept; hold everything
//   redirect_valid taken branch/jump; load redirect_pc
//   redirect_pc    target byte address
//   debug_hold     freeze fetch while the debug loader owns memory
//   if_instr       registered instruction to decode
//   if_pc          registered byte address of if_instr
//   if_valid       if_instr/if_pc hold a real instruction
//   misalign_err   one-cycle pulse after a redirect with nonzero low bits
//   fetch_count    number of instructions delivered (wraps)
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        nrst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        debug_hold,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_valid,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DEBUG = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] if_instr_nxt;
    logic [31:0] if_pc_nxt;
    logic        if_valid_nxt;
    logic        misalign_nxt;
    logic [31:0] fetch_count_nxt;

    assign imem_addr = {2'b00, pc[31:2]};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            if_instr     <= NOP_INSTR;
            if_pc        <= 32'h0;
            if_valid     <= 1'b0;
            misalign_err <= 1'b0;
            fetch_count  <= 32'h0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            if_instr     <= if_instr_nxt;
            if_pc        <= if_pc_nxt;
            if_valid     <= if_valid_nxt;
            misalign_err <= misalign_nxt;
            fetch_count  <= fetch_count_nxt;
        end
    end

    // Priority: debug_hold beats everything, then redirect, then stall.
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        if_instr_nxt    = if_instr;
        if_pc_nxt       = if_pc;
        if_valid_nxt    = if_valid;
        misalign_nxt    = 1'b0;
        fetch_count_nxt = fetch_count;

        if (debug_hold) begin
            state_nxt    = S_DEBUG;
            pc_nxt       = RESET_PC;
            if_valid_nxt = 1'b0;
            if_instr_nxt = NOP_INSTR;
        end else begin
            case (state)
                S_IDLE: begin
                    // pc held so memory can present its word before RUN
                    state_nxt    = S_RUN;
                    if_valid_nxt = 1'b0;
                    if_instr_nxt = NOP_INSTR;
                end
                S_RUN: begin
                    if (redirect_valid) begin
                        // Misaligned targets are truncated, flagged, and fetch carries on.
                        pc_nxt       = {redirect_pc[31:2], 2'b00};
                        if_valid_nxt = 1'b0;
                        if_instr_nxt = NOP_INSTR;
                        misalign_nxt = |redirect_pc[1:0];
                    end else if (!stall) begin
                        if_instr_nxt    = imem_instr;
                        if_pc_nxt       = pc;
                        if_valid_nxt    = 1'b1;
                        pc_nxt          = pc + 32'd4;
                        fetch_count_nxt = fetch_count + 32'd1;
                    end
                end
                S_DEBUG: begin
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt    = S_IDLE;
                    pc_nxt       = RESET_PC;
                    if_valid_nxt = 1'b0;
                    if_instr_nxt = NOP_INSTR;
                end
            endcase
        end
    end

endmodule
